load_store_multi: RTL

//   NCH independent fill/drain volume channels. Each channel ramps a CBITS-wide

---
 rtl/load_store_multi.sv | 106 ++++++++++
 1 files changed

// File: rtl/load_store_multi.sv
// Purpose : NCH independent fill/drain volume channels (per-lane occupancy/credit model).
// Latency : every output is registered; each update lands on the edge after its inputs are sampled.
// Backpressure: none. hold/!en freeze a channel; force_drain and clear override it; all_full is the AND of the full flops.
// Ports   : clk, rst (async active-low); per-channel en/hold/force_drain/clear inputs;
//           vol (channel i at [i*CBITS +: CBITS]), fill_mode, full, empty, full_pulse, all_full.
module load_store_multi #(
  parameter int NCH   = 4,
  parameter int CBITS = 14,
  parameter int CAP   = 10000,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       hold,
  input  logic [NCH-1:0]       force_drain,
  input  logic [NCH-1:0]       clear,
  output logic [NCH*CBITS-1:0] vol,
  output logic [NCH-1:0]       fill_mode,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       empty,
  output logic [NCH-1:0]       full_pulse,
  output logic                 all_full
);

  typedef enum logic {DRAIN = 1'b0, FILL = 1'b1} mode_e;

  // One extra bit of headroom so vol+STEP can never wrap before the clamp.
  localparam logic [CBITS:0] CAP_X  = (CBITS+1)'(CAP);
  localparam logic [CBITS:0] STEP_X = (CBITS+1)'(STEP);

  logic [CBITS-1:0] vol_q [NCH];
  logic [CBITS-1:0] vol_d [NCH];
  mode_e            mode_q [NCH];
  mode_e            mode_d [NCH];
  logic [NCH-1:0]   full_q, full_d;
  logic [NCH-1:0]   empty_q, empty_d;
  logic [NCH-1:0]   pulse_q, pulse_d;

  function automatic logic [CBITS-1:0] fill_step(input logic [CBITS-1:0] v);
    logic [CBITS:0] sum;
    sum = {1'b0, v} + STEP_X;
    fill_step = (sum >= CAP_X) ? CAP_X[CBITS-1:0] : sum[CBITS-1:0];
  endfunction

  function automatic logic [CBITS-1:0] drain_step(input logic [CBITS-1:0] v);
    drain_step = ({1'b0, v} < STEP_X) ? '0 : v - STEP_X[CBITS-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      vol_d[i]  = vol_q[i];
      mode_d[i] = mode_q[i];
      if (clear[i]) begin
        vol_d[i]  = '0;
        mode_d[i] = FILL;
      end else if (force_drain[i]) begin
        mode_d[i] = DRAIN;
      end else if (en[i] && !hold[i]) begin
        if (mode_q[i] == FILL) begin
          // Turn-around costs one enabled cycle sitting at CAP.
          if ({1'b0, vol_q[i]} >= CAP_X) mode_d[i] = DRAIN;
          else                           vol_d[i]  = fill_step(vol_q[i]);
        end else begin
          if (vol_q[i] == '0) mode_d[i] = FILL;
          else                vol_d[i]  = drain_step(vol_q[i]);
        end
      end
      // Flags follow next-state vol so they line up with the vol output.
      full_d[i]  = ({1'b0, vol_d[i]} == CAP_X);
      empty_d[i] = (vol_d[i] == '0);
      pulse_d[i] = full_d[i] && ({1'b0, vol_q[i]} != CAP_X);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        vol_q[i]  <= '0;
        mode_q[i] <= DRAIN;
      end
      full_q  <= '0;
      empty_q <= '1;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        vol_q[i]  <= vol_d[i];
        mode_q[i] <= mode_d[i];
      end
      full_q  <= full_d;
      empty_q <= empty_d;
      pulse_q <= pulse_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign vol[g*CBITS +: CBITS] = vol_q[g];
    assign fill_mode[g]          = (mode_q[g] == FILL);
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign full_pulse = pulse_q;
  assign all_full   = &full_q;

endmodule
